qupls_decode_stage: RTL and testbench
=====================================

Name: qupls_decode_stage

Overview:
- LANES-wide registered decode stage: takes a fetch group of up to LANES extended instructions, decodes each lane in parallel and presents one decode_bus_t per lane to rename.
- Replaces the single-lane, enable-only decode register with a full valid/ready handshake, a 2-entry skid buffer, pipeline flush, a group sequence tag and a parametrised register-exception window.
- Sits between the instruction-extract/align stage and rename.

Parameters:
- LANES, 4, decode lanes per group (1..8).
- SKID_DEPTH, 2, output buffer entries (fixed 2; other values rejected by elaboration assert).
- SEQ_W, 6, width of group sequence tag.
- REGX_LO, 8'd28, QFEXT register-exception window lower bound (exclusive).
- REGX_HI, 8'd56, QFEXT register-exception window upper bound (exclusive).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- flush  in  1  discard all buffered and in-flight groups
- om  in  operating_mode_t  current operating mode
- ipl  in  3  interrupt priority level
- in_valid  in  1  input group valid
- in_ready  out  1  stage can accept a group this cycle
- in_lane_v  in  LANES  per-lane instruction valid
- in_ins  in  LANES x ex_instruction_t  instructions
- out_valid  out  1  output group valid
- out_ready  in  1  rename accepts group
- out_lane_v  out  LANES  per-lane valid (qualified by out_valid)
- out_db  out  LANES x decode_bus_t  decoded lanes
- out_seq  out  SEQ_W  group sequence tag
- occupancy  out  2  buffered group count (0..2)

Behaviour:
- Reset (rst low, asynchronous): both skid entries invalid; occupancy=0; out_valid=0; in_ready=1; seq counter=0. Every out_db lane is all-zero except nop=1, Rtz=1, alu=1. out_lane_v=0.
- Accept: a group is accepted when in_valid && in_ready at the clk edge. Latency is 1 cycle: the accepted group appears at out_* on the next cycle when the buffer was empty.
- in_ready = (occupancy<2) || (occupancy==2 && out_ready). It is combinational from registered state plus out_ready, so it is never dependent on in_valid.
- Output: out_* always reflect the head entry. A group retires when out_valid && out_ready. Simultaneous accept and retire keeps occupancy unchanged. Order is FIFO, with 2 entries and a 1-bit head pointer.
- Per-lane decode is combinational from in_ins and is registered on acceptance. Registered fields override the raw decode as follows:
  - mem = load|store|cstore|cload
  - sync = fence && ins[15:8]==8'hFF
  - pred = opcode==OP_PRED
  - predz = ins[47]
  - qfext = opcode==OP_QFEXT
  - cap, mvvr, jsri, ret, pushi and bstore use identical opcode/func tests
  - cpytgt, vec2, Rtv, Rav, Rbv and Rcv are 0
- regexc = qfext && any of Ra/Rb/Rc/Rt in the open interval (REGX_LO, REGX_HI). Both bounds are exclusive.
- Invalid lanes (in_lane_v[i]=0) are stored with the reset pattern for that lane, and out_lane_v[i]=0.
- Sequence: out_seq is the value of a SEQ_W counter latched at acceptance. The counter increments per accepted group and wraps from 2^SEQ_W-1 to 0.
- Flush: synchronous, highest priority. On the next cycle occupancy=0, out_valid=0 and all lanes return to the reset pattern. An input offered in the flush cycle is dropped even if in_ready=1. The seq counter is not reset by flush.
- Full with out_ready=0: in_ready=0 and all entries hold; no overwrite is allowed.
- out_valid=1 with out_ready=0: out_db and out_seq must stay stable (verified by assertion).
- Reset asserted mid-operation clears asynchronously to the reset state. Deassertion is synchronised externally.

Decomposition:
- QuplsPkg gets:
  - decode_group_t: lane valid mask, LANES x decode_bus_t, seq.
  - Constants DEC_LANES_MAX=8.
  - Function decode_reset_pattern().
- One sub-module, qupls_decode_lane: combinational single-lane decode. It instantiates the existing immediate, register and class decoders and applies the overrides and regexc window.
- The stage instantiates LANES copies of qupls_decode_lane via generate, plus the 2-entry skid FIFO logic inline.

Test Plan:
- Reset then single group: rst low 3 cycles, release; offer LANES=4 group of NOPs with in_lane_v=4'b1111 -> out_valid=1 next cycle, out_seq=0, occupancy=1, each lane nop=1.
- Backpressure: out_ready=0, offer 3 consecutive groups -> groups 0 and 1 buffered, in_ready=0 on third, occupancy=2, out_db stable. Then out_ready=1 -> seq 0,1,2 delivered in order with no loss or duplication.
- regexc window: QFEXT with Ra=29 -> regexc=1; Ra=28 -> 0; Rt=55 -> 1; Rt=56 -> 0; non-QFEXT with Ra=30 -> 0.
- Flush with simultaneous input: occupancy=2, assert flush with in_valid=1 -> next cycle out_valid=0 and occupancy=0. The next accepted group has seq = previous counter value, not 0.
- Seq wrap and partial lanes: SEQ_W=6, accept 65 groups with in_lane_v=4'b0101 -> out_seq sequence ...,63,0. Lanes 1 and 3 have out_lane_v=0 and carry the reset pattern.
- Async reset mid-stream: drop rst between clock edges while occupancy=2 -> outputs reach the reset values before the next clk edge, and in_ready=1.

Source files
------------

// File: rtl/qupls_decode_stage_pkg.sv
// Shared types for the QUPLS decode stage: instruction, decode bus and group formats,
// opcode map and the idle decode pattern.
package qupls_decode_stage_pkg;

    localparam int DEC_LANES_MAX = 8;

    localparam logic [6:0] OP_NOP    = 7'h00;
    localparam logic [6:0] OP_ADD    = 7'h04;
    localparam logic [6:0] OP_CSR    = 7'h07;
    localparam logic [6:0] OP_SEI    = 7'h08;
    localparam logic [6:0] OP_LOAD   = 7'h10;
    localparam logic [6:0] OP_STORE  = 7'h11;
    localparam logic [6:0] OP_CLOAD  = 7'h12;
    localparam logic [6:0] OP_CSTORE = 7'h13;
    localparam logic [6:0] OP_FENCE  = 7'h20;
    localparam logic [6:0] OP_PRED   = 7'h21;
    localparam logic [6:0] OP_QFEXT  = 7'h22;
    localparam logic [6:0] OP_CAP    = 7'h23;
    localparam logic [6:0] OP_MVVR   = 7'h24;
    localparam logic [6:0] OP_JSRI   = 7'h25;
    localparam logic [6:0] OP_RET    = 7'h26;
    localparam logic [6:0] OP_PUSHI  = 7'h27;
    localparam logic [5:0] FN_BSTORE = 6'h3F;

    typedef enum logic [1:0] {
        OM_APP     = 2'd0,
        OM_SUPER   = 2'd1,
        OM_HYPER   = 2'd2,
        OM_MACHINE = 2'd3
    } operating_mode_t;

    // Layout: op[6:0] Rt[12:7] Ra[18:13] Rb[24:19] Rc[30:25] imm/func[46:31] predz[47]
    typedef struct packed {
        logic [47:0] ins;
    } ex_instruction_t;

    typedef struct packed {
        logic        nop, Rtz, alu, mem, load, store, cload, cstore;
        logic        fence, sync, pred, predz, qfext, regexc;
        logic        cap, mvvr, jsri, ret, pushi, bstore;
        logic        cpytgt, vec2, Rtv, Rav, Rbv, Rcv, privexc;
        logic [7:0]  Rt, Ra, Rb, Rc;
        logic [15:0] imm;
    } decode_bus_t;

    typedef struct packed {
        logic [DEC_LANES_MAX-1:0]       lane_v;
        decode_bus_t [DEC_LANES_MAX-1:0] db;
        logic [7:0]                      seq;
    } decode_group_t;

    function automatic decode_bus_t decode_reset_pattern();
        decode_bus_t d;
        d     = '0;
        d.nop = 1'b1;
        d.Rtz = 1'b1;
        d.alu = 1'b1;
        return d;
    endfunction

    function automatic logic in_window(input logic [7:0] r, input logic [7:0] lo,
                                       input logic [7:0] hi);
        return (r > lo) && (r < hi);
    endfunction

endpackage

// File: rtl/qupls_decode_lane.sv
// Combinational single-lane decode: register/immediate fields, instruction class
// flags, and the QFEXT register-exception window.
module qupls_decode_lane
    import qupls_decode_stage_pkg::*;
#(
    parameter logic [7:0] REGX_LO = 8'd28,
    parameter logic [7:0] REGX_HI = 8'd56
) (
    input  operating_mode_t om,
    input  logic [2:0]      ipl,
    input  ex_instruction_t ins,
    output decode_bus_t     db
);
    logic [47:0] ir;
    logic [6:0]  op;
    logic [5:0]  func;

    assign ir   = ins.ins;
    assign op   = ir[6:0];
    assign func = ir[36:31];

    always_comb begin
        // cpytgt, vec2 and the vector-register flags stay at this zero default.
        db     = '0;
        db.Rt  = {2'b00, ir[12:7]};
        db.Ra  = {2'b00, ir[18:13]};
        db.Rb  = {2'b00, ir[24:19]};
        db.Rc  = {2'b00, ir[30:25]};
        db.imm = ir[46:31];

        db.nop    = (op == OP_NOP);
        db.alu    = (op == OP_NOP) || (op == OP_ADD);
        db.Rtz    = (ir[12:7] == 6'd0);
        db.load   = (op == OP_LOAD);
        db.store  = (op == OP_STORE);
        db.cload  = (op == OP_CLOAD);
        db.cstore = (op == OP_CSTORE);
        db.mem    = db.load | db.store | db.cstore | db.cload;
        db.fence  = (op == OP_FENCE);
        db.sync   = db.fence && (ir[15:8] == 8'hFF);
        db.pred   = (op == OP_PRED);
        db.predz  = ir[47];
        db.qfext  = (op == OP_QFEXT);
        db.regexc = db.qfext && (in_window(db.Ra, REGX_LO, REGX_HI) ||
                                 in_window(db.Rb, REGX_LO, REGX_HI) ||
                                 in_window(db.Rc, REGX_LO, REGX_HI) ||
                                 in_window(db.Rt, REGX_LO, REGX_HI));
        db.cap    = (op == OP_CAP);
        db.mvvr   = (op == OP_MVVR);
        db.jsri   = (op == OP_JSRI);
        db.ret    = (op == OP_RET);
        db.pushi  = (op == OP_PUSHI);
        db.bstore = (op == OP_STORE) && (func == FN_BSTORE);
        // App mode may not touch CSRs nor lower the interrupt level.
        db.privexc = (om == OM_APP) &&
                     ((op == OP_CSR) || ((op == OP_SEI) && (ir[9:7] < ipl)));
    end

endmodule

// File: rtl/qupls_decode_stage.sv
// LANES-wide registered decode stage with valid/ready handshake, 2-entry skid FIFO,
// flush and a per-group sequence tag.
module qupls_decode_stage
    import qupls_decode_stage_pkg::*;
#(
    parameter int         LANES      = 4,
    parameter int         SKID_DEPTH = 2,
    parameter int         SEQ_W      = 6,
    parameter logic [7:0] REGX_LO    = 8'd28,
    parameter logic [7:0] REGX_HI    = 8'd56
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  operating_mode_t         om,
    input  logic [2:0]              ipl,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_v,
    input  ex_instruction_t [LANES-1:0] in_ins,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lane_v,
    output decode_bus_t [LANES-1:0] out_db,
    output logic [SEQ_W-1:0]        out_seq,
    output logic [1:0]              occupancy
);
    typedef struct packed {
        logic [LANES-1:0]        lane_v;
        decode_bus_t [LANES-1:0] db;
        logic [SEQ_W-1:0]        seq;
    } group_t;

    if (SKID_DEPTH != 2) begin : g_bad_depth
        $error("qupls_decode_stage: SKID_DEPTH must be 2");
    end
    if (LANES < 1 || LANES > DEC_LANES_MAX) begin : g_bad_lanes
        $error("qupls_decode_stage: LANES out of range");
    end

    function automatic group_t idle_group();
        group_t g;
        g = '0;
        for (int i = 0; i < LANES; i++) g.db[i] = decode_reset_pattern();
        return g;
    endfunction

    decode_bus_t [LANES-1:0] dec;
    group_t                  ent [2];
    group_t                  new_grp;
    logic                    head, wr_ptr, accept, retire;
    logic [SEQ_W-1:0]        seq_cnt;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        qupls_decode_lane #(.REGX_LO(REGX_LO), .REGX_HI(REGX_HI)) u_lane (
            .om  (om),
            .ipl (ipl),
            .ins (in_ins[i]),
            .db  (dec[i])
        );
    end

    always_comb begin
        new_grp        = '0;
        new_grp.lane_v = in_lane_v;
        new_grp.seq    = seq_cnt;
        for (int i = 0; i < LANES; i++)
            new_grp.db[i] = in_lane_v[i] ? dec[i] : decode_reset_pattern();
    end

    assign out_valid  = (occupancy != 2'd0);
    assign in_ready   = (occupancy != 2'd2) || out_ready;
    assign accept     = in_valid && in_ready && !flush;
    assign retire     = out_valid && out_ready && !flush;
    // Tail slot: head when empty or full (full only writes while head retires).
    assign wr_ptr     = head ^ (occupancy == 2'd1);
    assign out_lane_v = ent[head].lane_v;
    assign out_db     = ent[head].db;
    assign out_seq    = ent[head].seq;

    // NOTE: the buffer is reset (not left X) so an empty stage presents the idle
    // decode pattern; the accept write follows the retire clear so it wins on a shared slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent[0]    <= idle_group();
            ent[1]    <= idle_group();
            head      <= 1'b0;
            occupancy <= 2'd0;
            seq_cnt   <= '0;
        end else if (flush) begin
            ent[0]    <= idle_group();
            ent[1]    <= idle_group();
            head      <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (retire) begin
                ent[head] <= idle_group();
                head      <= ~head;
            end
            if (accept) begin
                ent[wr_ptr] <= new_grp;
                seq_cnt     <= seq_cnt + SEQ_W'(1);
            end
            occupancy <= occupancy + 2'(accept) - 2'(retire);
        end
    end

    property p_hold_stable;
        @(posedge clk) disable iff (!rst)
            (out_valid && !out_ready && !flush) |=> ($stable(out_db) && $stable(out_seq));
    endproperty
    a_hold_stable: assert property (p_hold_stable);

endmodule

// File: tb/tb_qupls_decode_stage.sv
// Directed bench for qupls_decode_stage: handshake, backpressure, regexc window,
// flush, sequence wrap with partial lanes, and asynchronous reset.
module tb_qupls_decode_stage;
    import qupls_decode_stage_pkg::*;

    localparam int LANES = 4;
    localparam int SEQ_W = 6;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    flush = 1'b0;
    operating_mode_t         om = OM_MACHINE;
    logic [2:0]              ipl = 3'd0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [LANES-1:0]        in_lane_v = '0;
    ex_instruction_t [LANES-1:0] in_ins = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [LANES-1:0]        out_lane_v;
    decode_bus_t [LANES-1:0] out_db;
    logic [SEQ_W-1:0]        out_seq;
    logic [1:0]              occupancy;

    int vectors = 0;
    int miscompares = 0;

    qupls_decode_stage #(.LANES(LANES), .SKID_DEPTH(2), .SEQ_W(SEQ_W),
                         .REGX_LO(8'd28), .REGX_HI(8'd56)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .om         (om),
        .ipl        (ipl),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_lane_v  (in_lane_v),
        .in_ins     (in_ins),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_lane_v (out_lane_v),
        .out_db     (out_db),
        .out_seq    (out_seq),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_db(input string tag, input decode_bus_t obs, input decode_bus_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] mk(input logic [6:0] op, input logic [5:0] rt,
                                       input logic [5:0] ra, input logic [5:0] rb,
                                       input logic [5:0] rc);
        return {17'b0, rc, rb, ra, rt, op};
    endfunction

    decode_bus_t rst_pat;
    decode_bus_t exp_add;
    logic [47:0] rx_ins [7];
    logic        rx_exp [7];
    int          exp_seq;

    initial begin
        rst_pat     = '0;
        rst_pat.nop = 1'b1;
        rst_pat.Rtz = 1'b1;
        rst_pat.alu = 1'b1;

        exp_add     = '0;
        exp_add.alu = 1'b1;
        exp_add.Rt  = 8'd5;
        exp_add.Ra  = 8'd1;
        exp_add.Rb  = 8'd2;
        exp_add.Rc  = 8'd3;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_lane_v", 32'(out_lane_v), 32'd0);
        check("rst_seq", 32'(out_seq), 32'd0);
        check_db("rst_db0", out_db[0], rst_pat);
        check_db("rst_db3", out_db[3], rst_pat);
        rst = 1'b1;

        // Single NOP group, 1-cycle latency
        in_valid  = 1'b1;
        in_lane_v = 4'b1111;
        in_ins    = '0;
        step();
        check("nop_valid", 32'(out_valid), 32'd1);
        check("nop_seq", 32'(out_seq), 32'd0);
        check("nop_occ", 32'(occupancy), 32'd1);
        check("nop_lane_v", 32'(out_lane_v), 32'hF);
        for (int i = 0; i < LANES; i++) check("nop_flag", 32'(out_db[i].nop), 32'd1);
        check_db("nop_db2", out_db[2], rst_pat);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("nop_drain_occ", 32'(occupancy), 32'd0);
        check("nop_drain_valid", 32'(out_valid), 32'd0);

        // Backpressure: groups A(seq1), B(seq2), C(seq3)
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_lane_v = 4'b0001;
        in_ins[0].ins = mk(OP_ADD, 6'd5, 6'd1, 6'd2, 6'd3);
        step();
        check("bp_a_occ", 32'(occupancy), 32'd1);
        check("bp_a_seq", 32'(out_seq), 32'd1);
        check_db("bp_a_db", out_db[0], exp_add);
        in_ins[0].ins = mk(OP_LOAD, 6'd9, 6'd4, 6'd0, 6'd0);
        step();
        check("bp_b_occ", 32'(occupancy), 32'd2);
        check("bp_b_in_ready", 32'(in_ready), 32'd0);
        check("bp_b_seq", 32'(out_seq), 32'd1);
        check_db("bp_b_db_stable", out_db[0], exp_add);
        in_ins[0].ins = mk(OP_PUSHI, 6'd10, 6'd0, 6'd0, 6'd0);
        step();
        check("bp_full_occ", 32'(occupancy), 32'd2);
        check("bp_full_seq", 32'(out_seq), 32'd1);
        check_db("bp_full_db_stable", out_db[0], exp_add);
        out_ready = 1'b1;
        #1;
        check("bp_full_in_ready", 32'(in_ready), 32'd1);
        step();
        check("bp_swap_occ", 32'(occupancy), 32'd2);
        check("bp_swap_seq", 32'(out_seq), 32'd2);
        check("bp_swap_load", 32'(out_db[0].load), 32'd1);
        check("bp_swap_mem", 32'(out_db[0].mem), 32'd1);
        check("bp_swap_rt", 32'(out_db[0].Rt), 32'd9);
        in_valid = 1'b0;
        step();
        check("bp_c_seq", 32'(out_seq), 32'd3);
        check("bp_c_occ", 32'(occupancy), 32'd1);
        check("bp_c_pushi", 32'(out_db[0].pushi), 32'd1);
        step();
        check("bp_empty_occ", 32'(occupancy), 32'd0);
        check_db("bp_empty_db", out_db[0], rst_pat);

        // regexc window (exclusive bounds 28 and 56), seq 4..10
        rx_ins[0] = mk(OP_QFEXT, 6'd0, 6'd29, 6'd0, 6'd0);  rx_exp[0] = 1'b1;
        rx_ins[1] = mk(OP_QFEXT, 6'd0, 6'd28, 6'd0, 6'd0);  rx_exp[1] = 1'b0;
        rx_ins[2] = mk(OP_QFEXT, 6'd55, 6'd0, 6'd0, 6'd0);  rx_exp[2] = 1'b1;
        rx_ins[3] = mk(OP_QFEXT, 6'd56, 6'd0, 6'd0, 6'd0);  rx_exp[3] = 1'b0;
        rx_ins[4] = mk(OP_ADD, 6'd0, 6'd30, 6'd0, 6'd0);    rx_exp[4] = 1'b0;
        rx_ins[5] = mk(OP_QFEXT, 6'd0, 6'd0, 6'd40, 6'd0);  rx_exp[5] = 1'b1;
        rx_ins[6] = mk(OP_QFEXT, 6'd0, 6'd0, 6'd0, 6'd57);  rx_exp[6] = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_ins[0].ins = rx_ins[k];
            step();
            check("rx_regexc", 32'(out_db[0].regexc), 32'(rx_exp[k]));
            check("rx_seq", 32'(out_seq), 32'(4 + k));
        end

        // Fence with ins[15:8]=FF is a sync, seq 11
        in_ins[0].ins = 48'h0000_0000_FF20;
        step();
        check("sync_flag", 32'(out_db[0].sync), 32'd1);
        check("sync_fence", 32'(out_db[0].fence), 32'd1);
        in_valid = 1'b0;
        step();

        // Flush while full with an input offered and in_ready=1
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ins[0].ins = mk(OP_ADD, 6'd1, 6'd0, 6'd0, 6'd0);
        step();
        step();
        check("fl_pre_occ", 32'(occupancy), 32'd2);
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("fl_in_ready", 32'(in_ready), 32'd1);
        step();
        check("fl_occ", 32'(occupancy), 32'd0);
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_lane_v", 32'(out_lane_v), 32'd0);
        check_db("fl_db0", out_db[0], rst_pat);
        flush = 1'b0;
        step();
        check("fl_next_seq", 32'(out_seq), 32'd14);
        check("fl_next_occ", 32'(occupancy), 32'd1);
        in_valid = 1'b0;
        step();

        // 65 groups with partial lanes, sequence wraps 63 -> 0
        in_valid  = 1'b1;
        in_lane_v = 4'b0101;
        for (int i = 0; i < LANES; i++) in_ins[i].ins = mk(OP_ADD, 6'd7, 6'd0, 6'd0, 6'd0);
        exp_seq = 15;
        for (int k = 0; k < 65; k++) begin
            step();
            check("wrap_seq", 32'(out_seq), 32'(exp_seq));
            if (exp_seq == 0) begin
                check("wrap_lane_v", 32'(out_lane_v), 32'h5);
                check_db("wrap_db1", out_db[1], rst_pat);
                check_db("wrap_db3", out_db[3], rst_pat);
                check("wrap_db2_rt", 32'(out_db[2].Rt), 32'd7);
            end
            exp_seq = (exp_seq + 1) % 64;
        end
        in_valid = 1'b0;
        step();

        // Asynchronous reset between edges while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_lane_v = 4'b1111;
        step();
        step();
        check("ar_pre_occ", 32'(occupancy), 32'd2);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("ar_occ", 32'(occupancy), 32'd0);
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_in_ready", 32'(in_ready), 32'd1);
        check("ar_lane_v", 32'(out_lane_v), 32'd0);
        check("ar_seq", 32'(out_seq), 32'd0);
        check_db("ar_db1", out_db[1], rst_pat);
        step();
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        check("ar_next_seq", 32'(out_seq), 32'd0);
        check("ar_next_occ", 32'(occupancy), 32'd1);
        in_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
